dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Owns the single data-RAM port (RAM_ADDRESS/RAM_DATAIN/RAM_DATAOUT) of the single-cycle core and shares it between three requesters.
- After reset it runs a program/data loader that streams words into RAM while the core is stalled. It then releases the core.
- While the core runs, the core has priority. A debug port gets idle cycles, with a starvation guard, plus an explicit halt mode.
- Sits between TOP's core datapath and the RAM instance.

Parameters:
ADDR_W, 10, RAM word-address width
DATA_W, 32, RAM word width
DEPTH, 1024, number of RAM words (loader pointer terminal count = DEPTH-1)
STARVE_LIMIT, 8, consecutive denied debug-request cycles before the core is forcibly stalled for one cycle
LOAD_EN, 1, 1 = start in LOAD after reset; 0 = start directly in RUN

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
CORE_REQ  in  1  core accesses data RAM this cycle
CORE_WE  in  1  core write enable
CORE_ADDR  in  ADDR_W  core word address
CORE_WDATA  in  DATA_W  core write data
CORE_RDATA  out  DATA_W  read data to core (combinational from RAM_DATAOUT)
CORE_STALL  out  1  core must hold its PC and not commit this cycle
LOAD_VALID  in  1  loader word valid
LOAD_DATA  in  DATA_W  loader word
LOAD_LAST  in  1  marks final loader word
LOAD_READY  out  1  loader word accepted when VALID&READY
DBG_REQ  in  1  debug access request (held until granted)
DBG_WE  in  1  debug write enable
DBG_ADDR  in  ADDR_W  debug word address
DBG_WDATA  in  DATA_W  debug write data
DBG_HALT  in  1  debug requests core halt
DBG_GNT  out  1  debug access performed this cycle
DBG_RVALID  out  1  registered read data valid (cycle after a read grant)
DBG_RDATA  out  DATA_W  registered debug read data
RUNNING  out  1  FSM in RUN state
RAM_ADDRESS  out  ADDR_W  RAM address
RAM_DATAIN  out  DATA_W  RAM write data
RAM_WE  out  1  RAM write enable
RAM_DATAOUT  in  DATA_W  RAM read data, combinational read

Behaviour:
- Reset (sync, high) state:
  - FSM = LOAD if LOAD_EN else RUN; load pointer = 0; starve counter = 0.
  - DBG_RVALID = 0, DBG_RDATA = 0.
  - Outputs in the first cycle after reset follow the reset state: LOAD gives CORE_STALL=1, LOAD_READY=1, RUNNING=0.
- Reset asserted mid-operation (including mid-load) aborts everything and returns to the reset state. A partial load is not resumed.
- States: LOAD, RUN, HALT.
- LOAD:
  - CORE_STALL=1, LOAD_READY=1, DBG_GNT=0.
  - On LOAD_VALID: RAM_WE=1, RAM_ADDRESS=pointer, RAM_DATAIN=LOAD_DATA; pointer increments.
  - If LOAD_LAST is set, or pointer==DEPTH-1 on an accepted word, go to RUN next cycle. No wrap-around.
  - DBG_REQ is ignored and held pending. DBG_HALT is ignored.
- RUN:
  - Core owns the port whenever CORE_REQ=1 and no forced stall: RAM signals come from the core; CORE_STALL=0.
  - Debug is granted (DBG_GNT=1) in any cycle with DBG_REQ=1 and CORE_REQ=0. Debug signals then drive the RAM.
  - Starve counter increments each cycle DBG_REQ=1 and not granted. It clears on grant or when DBG_REQ=0.
  - When the counter reaches STARVE_LIMIT: that cycle CORE_STALL=1, debug granted, counter cleared. The core retries its access the next cycle.
  - DBG_HALT=1 moves the FSM to HALT next cycle. The current cycle is unaffected.
- HALT:
  - CORE_STALL=1; debug granted every cycle DBG_REQ=1.
  - DBG_HALT=0 returns the FSM to RUN next cycle.
- Debug reads: on a grant with DBG_WE=0, DBG_RDATA<=RAM_DATAOUT and DBG_RVALID=1 for exactly one cycle after. Debug writes produce no RVALID.
- RAM_WE is never asserted for an access that lost arbitration. Only one source drives the RAM per cycle.
- Idle cycles: RAM_WE=0 and RAM_ADDRESS=CORE_ADDR.
- CORE_RDATA = RAM_DATAOUT always. It is meaningful only when the core owns the port.
- Simultaneous LOAD_LAST and DBG_HALT in LOAD: go to RUN. HALT is then taken the following cycle if DBG_HALT is still high.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (LOAD, RUN, HALT)
  - source-select enum (SRC_CORE, SRC_LOAD, SRC_DBG)
  - ADDR_W/DATA_W default constants
- Sub-module dmem_starve_cnt: saturating starvation counter with a limit-reached flag. Everything else stays in one module: FSM, mux, debug read register.

Test Plan:
- Load path: reset, then stream 4 words 0x00000013, 0x00100093, 0x00208133, 0xDEADBEEF with LAST on the 4th.
  - RAM writes at addresses 0..3; CORE_STALL=1 throughout; RUNNING=1 on the cycle after the 4th word.
- Debug gap grant: in RUN with CORE_REQ=0, debug read at address 2.
  - DBG_GNT=1 the same cycle; DBG_RVALID=1 with DBG_RDATA=0x00208133 the next cycle.
- Starvation guard: CORE_REQ=1 continuously with DBG_REQ held (write 0x12345678 to address 5).
  - Grant exactly on the 9th request cycle (STARVE_LIMIT=8), with CORE_STALL=1 only that cycle; RAM[5]=0x12345678.
- Halt mode: assert DBG_HALT for 6 cycles with back-to-back debug reads.
  - CORE_STALL=1 from the next cycle; every read granted; RUNNING returns to 1 one cycle after DBG_HALT drops.
- Mid-load reset: assert RESET after 2 of 4 load words.
  - Pointer returns to 0; next accepted word is written to address 0; no RAM_WE in the reset cycle.
- Pointer end: LOAD_EN=1, DEPTH=4, stream without LAST.
  - Transition to RUN after the word at address 3; LOAD_READY=0 afterwards.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-RAM port arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_CORE = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_DBG  = 2'd2
    } src_t;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Counts consecutive cycles a debug request waited without a grant.
// Flags when the wait reaches LIMIT.
module dmem_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic starving,
    output logic limit_hit
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (!starving) begin
            count <= '0;
        end else if (count != MAX) begin
            count <= count + CNT_W'(1);
        end
    end

    assign limit_hit = (count == MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-RAM port between the boot loader, the core and a debug port.
// The RAM has a combinational read, so the debug read data is registered here.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 8,
    parameter int LOAD_EN      = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CORE_REQ,
    input  logic              CORE_WE,
    input  logic [ADDR_W-1:0] CORE_ADDR,
    input  logic [DATA_W-1:0] CORE_WDATA,
    output logic [DATA_W-1:0] CORE_RDATA,
    output logic              CORE_STALL,
    input  logic              LOAD_VALID,
    input  logic [DATA_W-1:0] LOAD_DATA,
    input  logic              LOAD_LAST,
    output logic              LOAD_READY,
    input  logic              DBG_REQ,
    input  logic              DBG_WE,
    input  logic [ADDR_W-1:0] DBG_ADDR,
    input  logic [DATA_W-1:0] DBG_WDATA,
    input  logic              DBG_HALT,
    output logic              DBG_GNT,
    output logic              DBG_RVALID,
    output logic [DATA_W-1:0] DBG_RDATA,
    output logic              RUNNING,
    output logic [ADDR_W-1:0] RAM_ADDRESS,
    output logic [DATA_W-1:0] RAM_DATAIN,
    output logic              RAM_WE,
    input  logic [DATA_W-1:0] RAM_DATAOUT
);

    localparam state_t            RESET_STATE = (LOAD_EN != 0) ? ST_LOAD : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_PTR    = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            next_state;
    src_t              src;
    logic [ADDR_W-1:0] ptr;
    logic              load_accept;
    logic              core_owns;
    logic              starve_hit;
    logic              starving;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        next_state  = state;
        src         = SRC_CORE;
        core_owns   = 1'b0;
        load_accept = 1'b0;
        CORE_STALL  = 1'b0;
        LOAD_READY  = 1'b0;
        DBG_GNT     = 1'b0;

        unique case (state)
            ST_LOAD: begin
                CORE_STALL = 1'b1;
                LOAD_READY = 1'b1;
                if (LOAD_VALID) begin
                    src         = SRC_LOAD;
                    load_accept = 1'b1;
                    if (LOAD_LAST || ptr == LAST_PTR) begin
                        next_state = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (DBG_REQ && (starve_hit || !CORE_REQ)) begin
                    src        = SRC_DBG;
                    DBG_GNT    = 1'b1;
                    CORE_STALL = starve_hit;
                end else begin
                    core_owns = CORE_REQ;
                end
                if (DBG_HALT) begin
                    next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                CORE_STALL = 1'b1;
                if (DBG_REQ) begin
                    src     = SRC_DBG;
                    DBG_GNT = 1'b1;
                end
                if (!DBG_HALT) begin
                    next_state = ST_RUN;
                end
            end
            default: begin
                next_state = RESET_STATE;
            end
        endcase

        // A reset cycle performs no access of any kind.
        if (RESET) begin
            src         = SRC_CORE;
            core_owns   = 1'b0;
            load_accept = 1'b0;
            CORE_STALL  = 1'b1;
            LOAD_READY  = 1'b0;
            DBG_GNT     = 1'b0;
        end
    end

    always_comb begin
        RAM_ADDRESS = CORE_ADDR;
        RAM_DATAIN  = CORE_WDATA;
        RAM_WE      = 1'b0;
        unique case (src)
            SRC_LOAD: begin
                RAM_ADDRESS = ptr;
                RAM_DATAIN  = LOAD_DATA;
                RAM_WE      = 1'b1;
            end
            SRC_DBG: begin
                RAM_ADDRESS = DBG_ADDR;
                RAM_DATAIN  = DBG_WDATA;
                RAM_WE      = DBG_WE;
            end
            default: begin
                RAM_WE = core_owns && CORE_WE;
            end
        endcase
    end

    // The pointer holds at the last word instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr <= '0;
        end else if (load_accept && ptr != LAST_PTR) begin
            ptr <= ptr + ADDR_W'(1);
        end
    end

    assign starving = (state == ST_RUN) && DBG_REQ && !DBG_GNT && !RESET;

    dmem_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (CLK),
        .reset    (RESET),
        .starving (starving),
        .limit_hit(starve_hit)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            DBG_RVALID <= 1'b0;
            DBG_RDATA  <= '0;
        end else begin
            DBG_RVALID <= DBG_GNT && !DBG_WE;
            if (DBG_GNT && !DBG_WE) begin
                DBG_RDATA <= RAM_DATAOUT;
            end
        end
    end

    assign CORE_RDATA = RAM_DATAOUT;
    assign RUNNING    = (state == ST_RUN);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against a cycle-level behavioural model.
// A second instance with DEPTH=4 exercises the loader terminal count.
module tb_dmem_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int LIMIT = 8;

    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          reset, core_req, core_we, load_valid, load_last;
    logic          dbg_req, dbg_we, dbg_halt;
    logic [AW-1:0] core_addr, dbg_addr, ram_address;
    logic [DW-1:0] core_wdata, load_data, dbg_wdata;
    logic [DW-1:0] core_rdata, dbg_rdata, ram_datain, ram_dataout;
    logic          core_stall, load_ready, dbg_gnt, dbg_rvalid, running, ram_we;
    logic [DW-1:0] ram [DEPTH];

    assign ram_dataout = ram[ram_address];
    always @(posedge CLK) if (ram_we) ram[ram_address] <= ram_datain;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .LOAD_EN(1)) dut (
        .CLK(CLK), .RESET(reset),
        .CORE_REQ(core_req), .CORE_WE(core_we), .CORE_ADDR(core_addr), .CORE_WDATA(core_wdata),
        .CORE_RDATA(core_rdata), .CORE_STALL(core_stall),
        .LOAD_VALID(load_valid), .LOAD_DATA(load_data), .LOAD_LAST(load_last), .LOAD_READY(load_ready),
        .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wdata),
        .DBG_HALT(dbg_halt), .DBG_GNT(dbg_gnt), .DBG_RVALID(dbg_rvalid), .DBG_RDATA(dbg_rdata),
        .RUNNING(running), .RAM_ADDRESS(ram_address), .RAM_DATAIN(ram_datain), .RAM_WE(ram_we),
        .RAM_DATAOUT(ram_dataout)
    );

    // Small instance: only the loader is driven.
    logic          s_reset, s_valid;
    logic [DW-1:0] s_data, s_core_rdata, s_dbg_rdata, s_ram_datain;
    logic [AW-1:0] s_ram_address;
    logic          s_core_stall, s_load_ready, s_dbg_gnt, s_dbg_rvalid, s_running, s_ram_we;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .STARVE_LIMIT(LIMIT), .LOAD_EN(1)) dut_small (
        .CLK(CLK), .RESET(s_reset),
        .CORE_REQ(1'b0), .CORE_WE(1'b0), .CORE_ADDR({AW{1'b0}}), .CORE_WDATA({DW{1'b0}}),
        .CORE_RDATA(s_core_rdata), .CORE_STALL(s_core_stall),
        .LOAD_VALID(s_valid), .LOAD_DATA(s_data), .LOAD_LAST(1'b0), .LOAD_READY(s_load_ready),
        .DBG_REQ(1'b0), .DBG_WE(1'b0), .DBG_ADDR({AW{1'b0}}), .DBG_WDATA({DW{1'b0}}),
        .DBG_HALT(1'b0), .DBG_GNT(s_dbg_gnt), .DBG_RVALID(s_dbg_rvalid), .DBG_RDATA(s_dbg_rdata),
        .RUNNING(s_running), .RAM_ADDRESS(s_ram_address), .RAM_DATAIN(s_ram_datain), .RAM_WE(s_ram_we),
        .RAM_DATAOUT({DW{1'b0}})
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode, loader pointer, wait count and a sparse memory image.
    int            m_mode, m_ptr, m_starve;
    bit            m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_mem [int];

    function automatic logic [DW-1:0] mem_rd(input int a);
        return m_mem.exists(a) ? m_mem[a] : '0;
    endfunction

    task automatic model_reset();
        m_mode   = M_LOAD;
        m_ptr    = 0;
        m_starve = 0;
        m_rvalid = 0;
        m_rdata  = '0;
    endtask

    // Inputs are set in the low phase; outputs are compared, then one clock is taken.
    task automatic run_cycle(output bit granted);
        bit            e_stall, e_gnt, e_we, e_ready;
        int            e_addr;
        logic [DW-1:0] e_din;
        #1;
        e_stall = 0; e_gnt = 0; e_we = 0; e_ready = 0;
        e_addr  = int'(core_addr);
        e_din   = core_wdata;
        if (reset) begin
            e_stall = 1;
        end else if (m_mode == M_LOAD) begin
            e_stall = 1;
            e_ready = 1;
            if (load_valid) begin
                e_we = 1; e_addr = m_ptr; e_din = load_data;
            end
        end else begin
            if (m_mode == M_HALT) begin
                e_stall = 1;
                e_gnt   = dbg_req;
            end else begin
                e_gnt   = dbg_req && (!core_req || m_starve == LIMIT);
                e_stall = e_gnt && (m_starve == LIMIT);
                e_we    = !e_gnt && core_req && core_we;
            end
            if (e_gnt) begin
                e_we = dbg_we; e_addr = int'(dbg_addr); e_din = dbg_wdata;
            end
        end
        check("core_stall", core_stall, e_stall);
        check("load_ready", load_ready, e_ready);
        check("dbg_gnt", dbg_gnt, e_gnt);
        check("running", running, m_mode == M_RUN);
        check("ram_we", ram_we, e_we);
        check("ram_address", ram_address, e_addr);
        if (e_we) check("ram_datain", ram_datain, e_din);
        check("core_rdata", core_rdata, mem_rd(e_addr));
        check("dbg_rvalid", dbg_rvalid, m_rvalid);
        check("dbg_rdata", dbg_rdata, m_rdata);
        granted = e_gnt;

        @(posedge CLK);
        if (reset) begin
            model_reset();
        end else begin
            if (e_gnt && !dbg_we) m_rdata = mem_rd(e_addr);
            m_rvalid = e_gnt && !dbg_we;
            if (e_we) m_mem[e_addr] = e_din;
            case (m_mode)
                M_LOAD: if (load_valid) begin
                    if (load_last || m_ptr == DEPTH - 1) m_mode = M_RUN;
                    m_ptr++;
                end
                M_RUN: begin
                    m_starve = (dbg_req && !e_gnt) ? m_starve + 1 : 0;
                    if (dbg_halt) m_mode = M_HALT;
                end
                default: begin
                    m_starve = 0;
                    if (!dbg_halt) m_mode = M_RUN;
                end
            endcase
        end
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] prog [4];
        bit            g, pend;
        int            n, halt_left;

        prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093;
        prog[2] = 32'h0020_8133; prog[3] = 32'hDEAD_BEEF;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;

        reset = 1; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        load_valid = 0; load_last = 0; load_data = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_halt = 0;
        s_reset = 1; s_valid = 0; s_data = '0;
        model_reset();
        @(negedge CLK);
        run_cycle(g);
        reset = 0;
        s_reset = 0;

        // Two words, then a reset while a third word is offered.
        for (int i = 0; i < 2; i++) begin
            load_valid = 1; load_data = 32'hA5A5_0000 + i;
            run_cycle(g);
        end
        reset = 1; load_data = 32'h0BAD_0BAD;
        #1 check("reset_cycle_no_we", ram_we, 1'b0);
        run_cycle(g);
        reset = 0;

        // Full load; a pending debug write and a halt request must be ignored while loading.
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'd9; dbg_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1; load_data = prog[i]; load_last = (i == 3);
            dbg_halt = (i == 3);
            run_cycle(g);
        end
        load_valid = 0; load_last = 0;
        check("load_running_after_last", running, 1'b1);
        for (int i = 0; i < 4; i++) check($sformatf("load_ram%0d", i), ram[i], prog[i]);
        dbg_req = 0;
        run_cycle(g);                 // RUN with halt still high
        dbg_halt = 0;
        check("halt_after_load", running, 1'b0);
        run_cycle(g);                 // HALT for one cycle
        check("run_after_halt", running, 1'b1);

        // Debug read in an idle core cycle.
        core_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 10'd2;
        #1 check("gap_gnt", dbg_gnt, 1'b1);
        run_cycle(g);
        dbg_req = 0;
        check("gap_rvalid", dbg_rvalid, 1'b1);
        check("gap_rdata", dbg_rdata, 32'h0020_8133);
        run_cycle(g);
        check("gap_rvalid_one_cycle", dbg_rvalid, 1'b0);

        // Starvation guard with the core busy every cycle.
        core_req = 1; core_we = 0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'd5; dbg_wdata = 32'h1234_5678;
        n = 0; g = 0;
        while (!g && n < 20) begin
            core_addr = 10'($urandom_range(0, 3));
            n++;
            if (n == 9) #1 check("starve_stall", core_stall, 1'b1);
            run_cycle(g);
        end
        dbg_req = 0;
        check("starve_grant_cycle", n, 9);
        check("starve_ram5", ram[5], 32'h1234_5678);
        run_cycle(g);

        // Halt with back-to-back debug reads.
        dbg_halt = 1; dbg_req = 1; dbg_we = 0;
        for (int i = 0; i < 6; i++) begin
            dbg_addr = 10'($urandom_range(0, 5));
            if (i > 0) begin
                #1;
                check("halt_stall", core_stall, 1'b1);
                check("halt_gnt", dbg_gnt, 1'b1);
            end
            run_cycle(g);
        end
        dbg_halt = 0; dbg_req = 0;
        run_cycle(g);
        check("halt_exit_running", running, 1'b1);

        // Random traffic, with occasional resets that re-enter the loader.
        pend = 0; halt_left = 0;
        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(0, 149) == 0);
            core_req   = ($urandom_range(0, 3) != 0);
            core_we    = ($urandom_range(0, 3) == 0);
            core_addr  = 10'($urandom_range(0, 15));
            core_wdata = $urandom;
            load_valid = $urandom_range(0, 1);
            load_last  = $urandom_range(0, 1);
            load_data  = $urandom;
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend      = 1;
                dbg_we    = $urandom_range(0, 1);
                dbg_addr  = 10'($urandom_range(0, 15));
                dbg_wdata = $urandom;
            end
            dbg_req = pend;
            if (halt_left > 0) halt_left--;
            else if ($urandom_range(0, 30) == 0) halt_left = $urandom_range(1, 5);
            dbg_halt = (halt_left > 0);
            run_cycle(g);
            if (g) pend = 0;
        end
        reset = 0; dbg_req = 0; dbg_halt = 0; load_valid = 0;

        // Loader terminal count on the DEPTH=4 instance, no LAST.
        s_reset = 1;
        @(negedge CLK);
        s_reset = 0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_data = 32'hC0DE_0000 + i;
            #1;
            check("small_running_during_load", s_running, 1'b0);
            check("small_ready", s_load_ready, 1'b1);
            check("small_we", s_ram_we, 1'b1);
            check("small_addr", s_ram_address, i);
            @(negedge CLK);
        end
        #1;
        check("small_running_after_end", s_running, 1'b1);
        check("small_ready_after_end", s_load_ready, 1'b0);
        check("small_no_we_after_end", s_ram_we, 1'b0);
        s_valid = 0;
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
